// File: rtl/countdown_pkg.sv
// ============================================================================
// Module      : countdown_pkg
// Description : Shared state encoding, digit indices and digit limits for the
//               countdown-timer sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package countdown_pkg;

  typedef enum logic [1:0] {
    EDIT  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } cd_state_t;

  // Digit index doubles as the cursor position
  localparam int DIG_HR10  = 0;
  localparam int DIG_HR1   = 1;
  localparam int DIG_MIN10 = 2;
  localparam int DIG_MIN1  = 3;
  localparam int DIG_SEC10 = 4;
  localparam int DIG_SEC1  = 5;

  localparam logic [3:0] MIN10_MAX = 4'd5;
  localparam logic [3:0] SEC10_MAX = 4'd5;
  localparam logic [3:0] DIG_MAX   = 4'd9;

endpackage

`default_nettype wire

// File: rtl/cd_bcd_dec.sv
// ============================================================================
// Module      : cd_bcd_dec
// Description : Combinational 6-digit BCD decrement by one second with borrow
//               through sec/min/hour digits; flags an all-zero result.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cd_bcd_dec
  import countdown_pkg::*;
(
  input  logic [23:0] value,
  output logic [23:0] next,
  output logic        is_zero
);

  logic       w_borrow;
  logic [3:0] w_d;
  logic [3:0] w_lim;

  // Packed digit 0 is sec_1; digits 1 and 3 are the tens of seconds/minutes
  always_comb begin
    next     = value;
    w_borrow = 1'b1;
    w_d      = '0;
    w_lim    = '0;
    for (int i = 0; i < 6; i++) begin
      w_d   = value[i*4 +: 4];
      w_lim = (i == 1) ? SEC10_MAX : ((i == 3) ? MIN10_MAX : DIG_MAX);
      if (w_borrow) begin
        if (w_d == 4'd0) begin
          next[i*4 +: 4] = w_lim;
        end else begin
          next[i*4 +: 4] = w_d - 4'd1;
          w_borrow       = 1'b0;
        end
      end
    end
  end

  assign is_zero = (next == 24'd0);

endmodule

`default_nettype wire

// File: rtl/countdown_ctrl.sv
// ============================================================================
// Module      : countdown_ctrl
// Description : Countdown-timer sequencer: digit edit, run/pause/resume, alarm.
//               Optional blink_mask output enabled by defining CD_BLINK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module countdown_ctrl
  import countdown_pkg::*;
#(
  parameter int HR_MAX      = 23,
  parameter int DONE_HOLD_S = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sec_tick,
  input  logic       up,
  input  logic       down,
  input  logic       left,
  input  logic       right,
  input  logic       start,
  output logic [3:0] hr_10,
  output logic [3:0] hr_1,
  output logic [3:0] min_10,
  output logic [3:0] min_1,
  output logic [3:0] sec_10,
  output logic [3:0] sec_1,
  output logic [2:0] cursor,
  output logic       running,
  output logic       alarm
`ifdef CD_BLINK_EN
  ,
  output logic [5:0] blink_mask
`endif
);

  localparam logic [3:0] C_HR10_MAX = 4'(HR_MAX / 10);
  localparam logic [3:0] C_HR1_TOP  = 4'(HR_MAX % 10);
  localparam int         C_HOLD_W   = (DONE_HOLD_S > 1) ? $clog2(DONE_HOLD_S + 1) : 1;

  cd_state_t             r_state;
  logic [3:0]            r_dig [6];
  logic [23:0]           r_preset;
  logic [2:0]            r_cursor;
  logic [C_HOLD_W-1:0]   r_hold;
  logic                  r_running;
  logic                  r_alarm;
  logic [4:0]            r_btn_q;
`ifdef CD_BLINK_EN
  logic                  r_phase;
  logic [5:0]            r_mask;
`endif

  logic [4:0]  w_btn;
  logic [4:0]  w_press;
  logic [23:0] w_value;
  logic [23:0] w_dec_next;
  logic        w_dec_zero;
  logic [3:0]  w_cur;
  logic [3:0]  w_lim;
  logic [3:0]  w_dig_nx;
  logic        w_hold_done;

  // Bit order sets priority: start > left > right > up > down
  assign w_btn   = {start, left, right, up, down};
  assign w_press = w_btn & ~r_btn_q;
  assign w_value = {r_dig[0], r_dig[1], r_dig[2], r_dig[3], r_dig[4], r_dig[5]};

  cd_bcd_dec u_dec (
    .value   (w_value),
    .next    (w_dec_next),
    .is_zero (w_dec_zero)
  );

  always_comb begin
    w_cur = r_dig[r_cursor];
    case (r_cursor)
      3'(DIG_HR10):  w_lim = C_HR10_MAX;
      3'(DIG_HR1):   w_lim = (r_dig[DIG_HR10] == C_HR10_MAX) ? C_HR1_TOP : DIG_MAX;
      3'(DIG_MIN10): w_lim = MIN10_MAX;
      3'(DIG_SEC10): w_lim = SEC10_MAX;
      default:       w_lim = DIG_MAX;
    endcase
    if (w_press[1]) w_dig_nx = (w_cur >= w_lim) ? 4'd0 : w_cur + 4'd1;
    else            w_dig_nx = (w_cur == 4'd0) ? w_lim : w_cur - 4'd1;
  end

  assign w_hold_done = (DONE_HOLD_S != 0) && sec_tick && (int'(r_hold) == DONE_HOLD_S - 1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= EDIT;
      for (int i = 0; i < 6; i++) r_dig[i] <= '0;
      r_preset  <= '0;
      r_cursor  <= '0;
      r_hold    <= '0;
      r_running <= 1'b0;
      r_alarm   <= 1'b0;
      r_btn_q   <= '0;
`ifdef CD_BLINK_EN
      r_phase   <= 1'b0;
      r_mask    <= '0;
`endif
    end else begin
      r_btn_q <= w_btn;
      case (r_state)
        EDIT: begin
          if (w_press[4]) begin
            if (w_value != 24'd0) begin
              r_preset  <= w_value;
              r_state   <= RUN;
              r_running <= 1'b1;
`ifdef CD_BLINK_EN
              r_phase   <= 1'b0;
              r_mask    <= '0;
`endif
            end
          end else if (w_press[3] || w_press[2]) begin
            if (w_press[3]) r_cursor <= (r_cursor == 3'd0) ? 3'd5 : r_cursor - 3'd1;
            else            r_cursor <= (r_cursor == 3'd5) ? 3'd0 : r_cursor + 3'd1;
`ifdef CD_BLINK_EN
            r_phase <= 1'b0;
            r_mask  <= '0;
`endif
          end else if (w_press[1] || w_press[0]) begin
            r_dig[r_cursor] <= w_dig_nx;
            // Landing on the top tens-of-hours value may push hours past HR_MAX
            if (r_cursor == 3'(DIG_HR10) && w_dig_nx == C_HR10_MAX &&
                r_dig[DIG_HR1] > C_HR1_TOP)
              r_dig[DIG_HR1] <= C_HR1_TOP;
`ifdef CD_BLINK_EN
            r_phase <= 1'b0;
            r_mask  <= '0;
`endif
          end
`ifdef CD_BLINK_EN
          else if (sec_tick) begin
            r_phase <= ~r_phase;
            r_mask  <= r_phase ? 6'b000000 : (6'b100000 >> r_cursor);
          end
`endif
        end
        RUN: begin
          if (w_press[4]) begin
            r_state   <= PAUSE;
            r_running <= 1'b0;
          end else if (sec_tick) begin
            for (int i = 0; i < 6; i++) r_dig[i] <= w_dec_next[(5-i)*4 +: 4];
            if (w_dec_zero) begin
              r_state   <= DONE;
              r_running <= 1'b0;
              r_alarm   <= 1'b1;
              r_hold    <= '0;
`ifdef CD_BLINK_EN
              r_phase   <= 1'b0;
              r_mask    <= '0;
`endif
            end
          end
        end
        PAUSE: begin
          if (w_press[4]) begin
            r_state   <= RUN;
            r_running <= 1'b1;
          end else if (w_press[3] || w_press[2]) begin
            r_state <= EDIT;
`ifdef CD_BLINK_EN
            r_phase <= 1'b0;
            r_mask  <= '0;
`endif
          end
        end
        DONE: begin
          if (w_press[4] || w_hold_done) begin
            for (int i = 0; i < 6; i++) r_dig[i] <= r_preset[(5-i)*4 +: 4];
            r_state <= EDIT;
            r_alarm <= 1'b0;
            r_hold  <= '0;
`ifdef CD_BLINK_EN
            r_phase <= 1'b0;
            r_mask  <= '0;
`endif
          end else if (sec_tick) begin
            r_hold <= r_hold + 1'b1;
`ifdef CD_BLINK_EN
            r_phase <= ~r_phase;
            r_mask  <= r_phase ? 6'b000000 : 6'b111111;
`endif
          end
        end
        default: r_state <= EDIT;
      endcase
    end
  end

  assign hr_10   = r_dig[DIG_HR10];
  assign hr_1    = r_dig[DIG_HR1];
  assign min_10  = r_dig[DIG_MIN10];
  assign min_1   = r_dig[DIG_MIN1];
  assign sec_10  = r_dig[DIG_SEC10];
  assign sec_1   = r_dig[DIG_SEC1];
  assign cursor  = r_cursor;
  assign running = r_running;
  assign alarm   = r_alarm;
`ifdef CD_BLINK_EN
  assign blink_mask = r_mask;
`endif

endmodule

`default_nettype wire

// File: tb/tb_countdown_ctrl.sv
// ============================================================================
// Module      : tb_countdown_ctrl
// Description : Directed self-checking bench for countdown_ctrl (default build).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_countdown_ctrl;

  localparam logic [4:0] B_START = 5'b10000;
  localparam logic [4:0] B_LEFT  = 5'b01000;
  localparam logic [4:0] B_RIGHT = 5'b00100;
  localparam logic [4:0] B_UP    = 5'b00010;
  localparam logic [4:0] B_DOWN  = 5'b00001;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sec_tick = 1'b0;
  logic [4:0] btn = '0;
  logic [3:0] hr_10, hr_1, min_10, min_1, sec_10, sec_1;
  logic [2:0] cursor;
  logic       running, alarm;
`ifdef CD_BLINK_EN
  logic [5:0] blink_mask;
`endif

  int n_total = 0;
  int n_bad   = 0;

  logic [23:0] val;
  assign val = {hr_10, hr_1, min_10, min_1, sec_10, sec_1};

  always #5 clk = ~clk;

  countdown_ctrl #(.HR_MAX(23), .DONE_HOLD_S(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .sec_tick (sec_tick),
    .up       (btn[1]),
    .down     (btn[0]),
    .left     (btn[3]),
    .right    (btn[2]),
    .start    (btn[4]),
    .hr_10    (hr_10),
    .hr_1     (hr_1),
    .min_10   (min_10),
    .min_1    (min_1),
    .sec_10   (sec_10),
    .sec_1    (sec_1),
    .cursor   (cursor),
    .running  (running),
    .alarm    (alarm)
`ifdef CD_BLINK_EN
    ,
    .blink_mask (blink_mask)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic press(input logic [4:0] b);
    btn = b;
    cyc();
    btn = '0;
    cyc();
  endtask

  task automatic tick();
    sec_tick = 1'b1;
    cyc();
    sec_tick = 1'b0;
    cyc();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    cyc();
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    check("reset_val", 32'(val), 32'h000000);
    check("reset_cursor", 32'(cursor), 32'd0);
    check("reset_running", 32'(running), 32'd0);
    check("reset_alarm", 32'(alarm), 32'd0);

    // 1: left wraps cursor to sec_1, three ups, run down to zero
    press(B_LEFT);
    check("t1_cursor", 32'(cursor), 32'd5);
    for (int i = 0; i < 3; i++) press(B_UP);
    check("t1_val", 32'(val), 32'h000003);
    press(B_START);
    check("t1_running", 32'(running), 32'd1);
    tick();
    check("t1_tick1", 32'(val), 32'h000002);
    tick();
    tick();
    check("t1_zero", 32'(val), 32'h000000);
    check("t1_alarm", 32'(alarm), 32'd1);
    check("t1_run_off", 32'(running), 32'd0);

    // 5a: DONE auto-return after 10 ticks, reload preset
    for (int i = 0; i < 9; i++) tick();
    check("t5_alarm_held", 32'(alarm), 32'd1);
    check("t5_val_held", 32'(val), 32'h000000);
    tick();
    check("t5_alarm_off", 32'(alarm), 32'd0);
    check("t5_reload", 32'(val), 32'h000003);
    tick();
    check("t5_edit_ignores_tick", 32'(val), 32'h000003);

    // 5b: start acknowledges alarm immediately
    press(B_START);
    for (int i = 0; i < 3; i++) tick();
    check("t5b_alarm", 32'(alarm), 32'd1);
    press(B_START);
    check("t5b_ack_alarm", 32'(alarm), 32'd0);
    check("t5b_ack_val", 32'(val), 32'h000003);
    check("t5b_ack_run", 32'(running), 32'd0);

    // 2: borrow across hours and minutes
    do_reset();
    press(B_RIGHT);
    press(B_UP);
    check("t2_edit", 32'(val), 32'h010000);
    press(B_START);
    tick();
    check("t2_hr_borrow", 32'(val), 32'h005959);
    do_reset();
    for (int i = 0; i < 3; i++) press(B_RIGHT);
    press(B_UP);
    press(B_START);
    tick();
    check("t2_min_borrow", 32'(val), 32'h000059);

    // 3: hour limits with HR_MAX=23
    do_reset();
    press(B_RIGHT);
    press(B_DOWN);
    check("t3_hr1_wrap", 32'(val), 32'h090000);
    press(B_LEFT);
    press(B_UP);
    check("t3_hr10_1", 32'(val), 32'h190000);
    press(B_UP);
    check("t3_clamp", 32'(val), 32'h230000);
    press(B_UP);
    check("t3_hr10_wrap", 32'(val), 32'h030000);
    press(B_RIGHT);
    press(B_DOWN);
    check("t3_hr1_dec", 32'(val), 32'h020000);

    // Priority and held buttons
    do_reset();
    btn = B_LEFT | B_UP;
    cyc();
    btn = '0;
    cyc();
    check("prio_cursor", 32'(cursor), 32'd5);
    check("prio_val", 32'(val), 32'h000000);
    btn = B_UP;
    for (int i = 0; i < 4; i++) cyc();
    btn = '0;
    cyc();
    check("held_once", 32'(val), 32'h000001);

    // 4: start and tick together pause without decrement
    do_reset();
    press(B_LEFT);
    press(B_LEFT);
    press(B_UP);
    check("t4_val", 32'(val), 32'h000010);
    press(B_START);
    btn = B_START;
    sec_tick = 1'b1;
    cyc();
    btn = '0;
    sec_tick = 1'b0;
    cyc();
    check("t4_paused", 32'(running), 32'd0);
    check("t4_frozen", 32'(val), 32'h000010);
    tick();
    check("t4_pause_tick", 32'(val), 32'h000010);
    press(B_START);
    check("t4_resume", 32'(running), 32'd1);
    tick();
    check("t4_dec", 32'(val), 32'h000009);

    // PAUSE -> EDIT via left keeps digits and cursor
    press(B_START);
    press(B_LEFT);
    check("pause_edit_cursor", 32'(cursor), 32'd4);
    check("pause_edit_val", 32'(val), 32'h000009);
    press(B_UP);
    check("pause_edit_up", 32'(val), 32'h000019);

    // 6: start with zero stays in EDIT; reset mid-RUN
    do_reset();
    press(B_START);
    check("t6_zero_start", 32'(running), 32'd0);
    press(B_LEFT);
    for (int i = 0; i < 5; i++) press(B_UP);
    press(B_START);
    tick();
    check("t6_run", 32'(val), 32'h000004);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check("t6_rst_val", 32'(val), 32'h000000);
    check("t6_rst_cursor", 32'(cursor), 32'd0);
    check("t6_rst_running", 32'(running), 32'd0);
    check("t6_rst_alarm", 32'(alarm), 32'd0);
    tick();
    check("t6_edit_after", 32'(val), 32'h000000);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
